// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Gray/binary pointer helpers shared by both FIFO clock domains.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

  localparam int c_gray_w = 32;

  // Pointers carry one extra wrap bit beyond the RAM address.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [c_gray_w-1:0] bin2gray(input logic [c_gray_w-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [c_gray_w-1:0] gray2bin(input logic [c_gray_w-1:0] g);
    logic [c_gray_w-1:0] b;
    b[c_gray_w-1] = g[c_gray_w-1];
    for (int i = c_gray_w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop clock-domain-crossing synchroniser for Gray pointers.
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             wclk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_port.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_port
// Brief    : Async FIFO write-domain front end; optional almost_full output
//            enabled by defining WR_ALMOST_FULL_EN.
// Revision : 1.0
// ============================================================================
module fifo_wr_port
  import fifo_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int PTRWIDTH = 4
`ifdef WR_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH = 2
`endif
) (
  input  logic                wclk,
  input  logic                reset_L,
  input  logic                in_valid,
  input  logic [DWIDTH-1:0]   in_data,
  output logic                in_ready,
  input  logic [PTRWIDTH:0]   rdptr_gray,
  output logic                mem_wen,
  output logic [PTRWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0]   mem_wdata,
  output logic [PTRWIDTH:0]   wrptr_gray,
  output logic                full,
  output logic [PTRWIDTH:0]   wr_level
`ifdef WR_ALMOST_FULL_EN
  ,
  output logic                almost_full
`endif
);

  localparam int c_pw = ptr_width(PTRWIDTH);
  typedef logic [c_pw-1:0] ptr_t;

  logic                r_skid_valid;
  logic [DWIDTH-1:0]   r_skid_data;
  logic                r_mem_wen;
  logic [PTRWIDTH-1:0] r_mem_waddr;
  logic [DWIDTH-1:0]   r_mem_wdata;
  ptr_t                r_wrptr_bin;
  ptr_t                r_wrptr_gray;
  logic                r_full;

  ptr_t                w_rsync;
  ptr_t                w_rdptr_bin;
  ptr_t                w_wrptr_bin_next;
  ptr_t                w_full_target;
  logic                w_fire;
  logic [DWIDTH-1:0]   w_word;

  sync_2ff #(.WIDTH(c_pw)) u_rsync (
    .wclk    (wclk),
    .reset_L (reset_L),
    .d       (rdptr_gray),
    .q       (w_rsync)
  );

  // The skid word always goes first so stream order survives a full stall.
  always_comb begin
    w_fire = 1'b0;
    w_word = in_data;
    if (!r_full) begin
      w_fire = r_skid_valid || in_valid;
    end
    if (r_skid_valid) begin
      w_word = r_skid_data;
    end
  end

  assign w_wrptr_bin_next = r_wrptr_bin + ptr_t'(w_fire);
  assign w_rdptr_bin      = ptr_t'(gray2bin(c_gray_w'(w_rsync)));
  assign w_full_target    = {~w_rsync[PTRWIDTH:PTRWIDTH-1], w_rsync[PTRWIDTH-2:0]};

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (r_skid_valid) begin
      if (!r_full) begin
        r_skid_valid <= 1'b0;
      end
    end else if (in_valid && r_full) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      r_mem_wen    <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_wrptr_bin  <= '0;
      r_wrptr_gray <= '0;
      r_full       <= 1'b0;
    end else begin
      r_mem_wen <= w_fire;
      if (w_fire) begin
        r_mem_waddr <= r_wrptr_bin[PTRWIDTH-1:0];
        r_mem_wdata <= w_word;
      end
      r_wrptr_bin <= w_wrptr_bin_next;
      // Published one edge after the increment, when the RAM holds the word.
      r_wrptr_gray <= ptr_t'(bin2gray(c_gray_w'(r_wrptr_bin)));
      r_full       <= (ptr_t'(bin2gray(c_gray_w'(w_wrptr_bin_next))) == w_full_target);
    end
  end

`ifdef WR_ALMOST_FULL_EN
  localparam ptr_t c_af_level = ptr_t'((2 ** PTRWIDTH) - AF_THRESH);

  logic r_almost_full;
  ptr_t w_level_next;

  assign w_level_next = w_wrptr_bin_next - w_rdptr_bin;

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_next >= c_af_level);
    end
  end

  assign almost_full = r_almost_full;
`endif

  assign in_ready   = reset_L & ~r_skid_valid;
  assign mem_wen    = r_mem_wen;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;
  assign wrptr_gray = r_wrptr_gray;
  assign full       = r_full;
  assign wr_level   = r_wrptr_bin - w_rdptr_bin;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_port
// Brief    : Directed self-checking bench for fifo_wr_port (PTRWIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_port;

  logic       wclk       = 1'b0;
  logic       reset_L    = 1'b0;
  logic       in_valid   = 1'b0;
  logic [7:0] in_data    = 8'h00;
  logic [4:0] rdptr_gray = 5'b00000;
  logic       in_ready;
  logic       mem_wen;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [4:0] wrptr_gray;
  logic       full;
  logic [4:0] wr_level;
`ifdef WR_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] wlog_q[$];

  fifo_wr_port #(.DWIDTH(8), .PTRWIDTH(4)) dut (
    .wclk       (wclk),
    .reset_L    (reset_L),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rdptr_gray (rdptr_gray),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .wrptr_gray (wrptr_gray),
    .full       (full),
    .wr_level   (wr_level)
`ifdef WR_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  always #5 wclk = ~wclk;

  // Record every RAM write the way the RAM itself would capture it.
  always @(posedge wclk) begin
    if (mem_wen) wlog_q.push_back({mem_waddr, mem_wdata});
  end

  function automatic logic [4:0] g(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge wclk);
    #1;
    n_checks++; if (mem_wen !== 1'b0)      begin n_fail++; $display("FAIL rst_wen: got %0b want 0", mem_wen); end
    n_checks++; if (mem_waddr !== 4'h0)    begin n_fail++; $display("FAIL rst_waddr: got %0h want 0", mem_waddr); end
    n_checks++; if (mem_wdata !== 8'h00)   begin n_fail++; $display("FAIL rst_wdata: got %0h want 0", mem_wdata); end
    n_checks++; if (wrptr_gray !== 5'b0)   begin n_fail++; $display("FAIL rst_wrgray: got %0b want 0", wrptr_gray); end
    n_checks++; if (full !== 1'b0)         begin n_fail++; $display("FAIL rst_full: got %0b want 0", full); end
    n_checks++; if (wr_level !== 5'd0)     begin n_fail++; $display("FAIL rst_level: got %0d want 0", wr_level); end
    n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_ready: got %0b want 0", in_ready); end
    reset_L = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_ready_rel: got %0b want 1", in_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      tick();
      n_checks++; if (mem_wen !== 1'b1)             begin n_fail++; $display("FAIL fill_wen[%0d]: got %0b want 1", i, mem_wen); end
      n_checks++; if (mem_waddr !== 4'(i))          begin n_fail++; $display("FAIL fill_waddr[%0d]: got %0h want %0h", i, mem_waddr, 4'(i)); end
      n_checks++; if (mem_wdata !== 8'hA0 + 8'(i))  begin n_fail++; $display("FAIL fill_wdata[%0d]: got %0h want %0h", i, mem_wdata, 8'hA0 + 8'(i)); end
      if (i == 1) begin
        n_checks++; if (wrptr_gray !== 5'b00001)    begin n_fail++; $display("FAIL fill_gray_lat: got %0b want 00001", wrptr_gray); end
      end
    end
    n_checks++; if (full !== 1'b1)         begin n_fail++; $display("FAIL fill_full: got %0b want 1", full); end
    n_checks++; if (wr_level !== 5'd16)    begin n_fail++; $display("FAIL fill_level: got %0d want 16", wr_level); end
    n_checks++; if (wrptr_gray !== 5'b01000) begin n_fail++; $display("FAIL fill_gray15: got %0b want 01000", wrptr_gray); end
    in_data = 8'hB0;
    tick();
    n_checks++; if (mem_wen !== 1'b0)      begin n_fail++; $display("FAIL skid_wen: got %0b want 0", mem_wen); end
    n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL skid_ready: got %0b want 0", in_ready); end
    n_checks++; if (wrptr_gray !== 5'b11000) begin n_fail++; $display("FAIL fill_gray16: got %0b want 11000", wrptr_gray); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (mem_wen !== 1'b0)      begin n_fail++; $display("FAIL skid_hold_wen: got %0b want 0", mem_wen); end
    n_checks++; if (wr_level !== 5'd16)    begin n_fail++; $display("FAIL skid_hold_level: got %0d want 16", wr_level); end
  endtask

  task automatic test_skid_drain();
    rdptr_gray = 5'b00001;
    tick();
    n_checks++; if (full !== 1'b1)         begin n_fail++; $display("FAIL drain_full1: got %0b want 1", full); end
    tick();
    n_checks++; if (wr_level !== 5'd15)    begin n_fail++; $display("FAIL drain_level2: got %0d want 15", wr_level); end
    n_checks++; if (full !== 1'b1)         begin n_fail++; $display("FAIL drain_full2: got %0b want 1", full); end
    tick();
    n_checks++; if (full !== 1'b0)         begin n_fail++; $display("FAIL drain_full3: got %0b want 0", full); end
    n_checks++; if (mem_wen !== 1'b0)      begin n_fail++; $display("FAIL drain_wen3: got %0b want 0", mem_wen); end
    tick();
    n_checks++; if (mem_wen !== 1'b1)      begin n_fail++; $display("FAIL drain_wen4: got %0b want 1", mem_wen); end
    n_checks++; if (mem_waddr !== 4'h0)    begin n_fail++; $display("FAIL drain_waddr: got %0h want 0", mem_waddr); end
    n_checks++; if (mem_wdata !== 8'hB0)   begin n_fail++; $display("FAIL drain_wdata: got %0h want b0", mem_wdata); end
    n_checks++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL drain_ready: got %0b want 1", in_ready); end
    n_checks++; if (full !== 1'b1)         begin n_fail++; $display("FAIL drain_refull: got %0b want 1", full); end
    n_checks++; if (wr_level !== 5'd16)    begin n_fail++; $display("FAIL drain_level4: got %0d want 16", wr_level); end
  endtask

  task automatic test_wrap();
    rdptr_gray = 5'b11001;
    repeat (3) tick();
    n_checks++; if (full !== 1'b0)         begin n_fail++; $display("FAIL wrap_empty_full: got %0b want 0", full); end
    n_checks++; if (wr_level !== 5'd0)     begin n_fail++; $display("FAIL wrap_empty_level: got %0d want 0", wr_level); end
    for (int i = 1; i <= 20; i++) begin
      in_valid   = 1'b1;
      in_data    = 8'h40 + 8'(i);
      rdptr_gray = g(16 + i);
      tick();
      n_checks++; if (mem_wen !== 1'b1)            begin n_fail++; $display("FAIL wrap_wen[%0d]: got %0b want 1", i, mem_wen); end
      n_checks++; if (mem_waddr !== 4'(16 + i))    begin n_fail++; $display("FAIL wrap_waddr[%0d]: got %0h want %0h", i, mem_waddr, 4'(16 + i)); end
      n_checks++; if (full !== 1'b0)               begin n_fail++; $display("FAIL wrap_full[%0d]: got %0b want 0", i, full); end
      n_checks++; if (wrptr_gray !== g(16 + i))    begin n_fail++; $display("FAIL wrap_gray[%0d]: got %0b want %0b", i, wrptr_gray, g(16 + i)); end
      if (i == 15) begin
        n_checks++; if (wrptr_gray !== 5'b10000)   begin n_fail++; $display("FAIL wrap_gray31: got %0b want 10000", wrptr_gray); end
      end
      if (i == 16) begin
        n_checks++; if (wrptr_gray !== 5'b00000)   begin n_fail++; $display("FAIL wrap_gray0: got %0b want 00000", wrptr_gray); end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    rdptr_gray = g(5);
    repeat (3) tick();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      tick();
    end
    n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL mid_skid_ready: got %0b want 0", in_ready); end
    #3;
    reset_L    = 1'b0;
    rdptr_gray = 5'b00000;
    #1;
    n_checks++; if (mem_wen !== 1'b0)      begin n_fail++; $display("FAIL mid_wen: got %0b want 0", mem_wen); end
    n_checks++; if (mem_waddr !== 4'h0)    begin n_fail++; $display("FAIL mid_waddr: got %0h want 0", mem_waddr); end
    n_checks++; if (mem_wdata !== 8'h00)   begin n_fail++; $display("FAIL mid_wdata: got %0h want 0", mem_wdata); end
    n_checks++; if (wrptr_gray !== 5'b0)   begin n_fail++; $display("FAIL mid_gray: got %0b want 0", wrptr_gray); end
    n_checks++; if (full !== 1'b0)         begin n_fail++; $display("FAIL mid_full: got %0b want 0", full); end
    n_checks++; if (wr_level !== 5'd0)     begin n_fail++; $display("FAIL mid_level: got %0d want 0", wr_level); end
    n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL mid_ready: got %0b want 0", in_ready); end
    repeat (2) tick();
    reset_L = 1'b1;
    in_data = 8'h5A;
    tick();
    n_checks++; if (mem_wen !== 1'b1)      begin n_fail++; $display("FAIL post_rst_wen: got %0b want 1", mem_wen); end
    n_checks++; if (mem_waddr !== 4'h0)    begin n_fail++; $display("FAIL post_rst_waddr: got %0h want 0", mem_waddr); end
    n_checks++; if (mem_wdata !== 8'h5A)   begin n_fail++; $display("FAIL post_rst_wdata: got %0h want 5a", mem_wdata); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int base;
    int src;
    int rd;
    int steps;
    logic acc;
    logic last;
    reset_L    = 1'b0;
    rdptr_gray = 5'b00000;
    tick();
    reset_L = 1'b1;
    tick();
    base  = wlog_q.size();
    src   = 0;
    rd    = 0;
    steps = 0;
    in_valid = 1'b1;
    while (src < 20 && steps < 200) begin
      in_data = 8'hD0 + 8'(src);
      if (src >= 15 && rd < 4) begin
        rd++;
        rdptr_gray = g(rd);
      end
      acc  = in_ready;
      last = (src == 15) && acc;
      tick();
      steps++;
      if (acc) src++;
      if (last) begin
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL b2b_last_full: got %0b want 1", full); end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (steps >= 200)          begin n_fail++; $display("FAIL b2b_timeout: got %0d accepted want 20", src); end
    repeat (10) tick();
    n_checks++; if (wlog_q.size() - base !== 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", wlog_q.size() - base); end
    for (int i = 0; i < 20; i++) begin
      if (base + i < wlog_q.size()) begin
        n_checks++;
        if (wlog_q[base + i] !== {4'(i), 8'hD0 + 8'(i)}) begin
          n_fail++; $display("FAIL b2b_word[%0d]: got %03h want %03h", i, wlog_q[base + i], {4'(i), 8'hD0 + 8'(i)});
        end
      end
    end
    n_checks++; if (full !== 1'b1)         begin n_fail++; $display("FAIL b2b_full: got %0b want 1", full); end
    n_checks++; if (wr_level !== 5'd16)    begin n_fail++; $display("FAIL b2b_level: got %0d want 16", wr_level); end
    n_checks++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", in_ready); end
  endtask

`ifdef WR_ALMOST_FULL_EN
  task automatic test_almost_full();
    reset_L    = 1'b0;
    rdptr_gray = 5'b00000;
    tick();
    n_checks++; if (almost_full !== 1'b0)  begin n_fail++; $display("FAIL af_rst: got %0b want 0", almost_full); end
    reset_L = 1'b1;
    tick();
    for (int i = 1; i <= 14; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      if (i == 13) begin
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_13: got %0b want 0", almost_full); end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (almost_full !== 1'b1)  begin n_fail++; $display("FAIL af_14: got %0b want 1", almost_full); end
    n_checks++; if (wr_level !== 5'd14)    begin n_fail++; $display("FAIL af_level14: got %0d want 14", wr_level); end
    rdptr_gray = g(1);
    repeat (2) tick();
    n_checks++; if (wr_level !== 5'd13)    begin n_fail++; $display("FAIL af_level13: got %0d want 13", wr_level); end
    tick();
    n_checks++; if (almost_full !== 1'b0)  begin n_fail++; $display("FAIL af_drop: got %0b want 0", almost_full); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_skid_drain();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef WR_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
